// File: rtl/ddr3_req_scheduler.sv
// rtl/ddr3_req_scheduler.sv - single-command request scheduler with owned refresh timer in front of ddr3_controller
// Optional feature macro: REFRESH_POSTPONE_EN (user traffic may postpone refresh until credit saturates)
module ddr3_req_scheduler #(
  parameter int REFRESH_CYCLES = 779,
  parameter int MAX_POSTPONE   = 8,
  parameter int RD_TIMEOUT     = 255
) (
  input  logic        pclk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [25:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mc_rd,
  output logic        mc_wr,
  output logic        mc_refresh,
  output logic [25:0] mc_addr,
  output logic [15:0] mc_din,
  input  logic [15:0] mc_dout,
  input  logic        mc_data_ready,
  input  logic        mc_busy,
  output logic [3:0]  refresh_credit,
  output logic        refresh_overrun
);

  localparam int TW = $clog2(REFRESH_CYCLES);
  localparam int OW = $clog2(RD_TIMEOUT + 1);
  localparam logic [3:0]    CREDIT_MAX = 4'(MAX_POSTPONE);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_CYCLES - 1);
  localparam logic [OW-1:0] TMO_LAST   = OW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          tick;
  logic          refresh_sel;
  logic          refresh_go;
  logic          accept;
  logic          cmd_rd;   // command in flight is a read (needs a response)
  logic          rd_done;  // read response already produced (data or timeout)
  logic [OW-1:0] tmo;

  assign tick = (timer == TIMER_LAST);

`ifdef REFRESH_POSTPONE_EN
  assign refresh_sel = (refresh_credit != 4'd0) && (!req_valid || refresh_credit == CREDIT_MAX);
`else
  assign refresh_sel = (refresh_credit != 4'd0);
`endif

  // Reset gating keeps the handshake low while the block is held in reset.
  assign req_ready  = resetn && (state == IDLE) && !mc_busy && !refresh_sel;
  assign accept     = req_valid && req_ready;
  assign refresh_go = (state == IDLE) && !mc_busy && refresh_sel;

  // Free-running refresh interval timer; its wrap is the refresh tick.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Refresh credit: ticks add, issued refreshes subtract, both together cancel.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      refresh_credit  <= 4'd0;
      refresh_overrun <= 1'b0;
    end else begin
      if (tick && refresh_credit == CREDIT_MAX) begin
        refresh_overrun <= 1'b1;
      end
      if (tick && !refresh_go) begin
        if (refresh_credit != CREDIT_MAX) begin
          refresh_credit <= refresh_credit + 4'd1;
        end
      end else if (!tick && refresh_go) begin
        refresh_credit <= refresh_credit - 4'd1;
      end
    end
  end

  // Command FSM with registered controller pulses and read response.
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mc_rd      <= 1'b0;
      mc_wr      <= 1'b0;
      mc_refresh <= 1'b0;
      mc_addr    <= '0;
      mc_din     <= '0;
      cmd_rd     <= 1'b0;
      rd_done    <= 1'b0;
      tmo        <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      mc_rd      <= 1'b0;
      mc_wr      <= 1'b0;
      mc_refresh <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (refresh_go) begin
            cmd_rd     <= 1'b0;
            mc_refresh <= 1'b1;
            state      <= ISSUE;
          end else if (accept) begin
            mc_addr <= req_addr;
            mc_din  <= req_wdata;
            cmd_rd  <= !req_we;
            mc_wr   <= req_we;
            mc_rd   <= !req_we;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // Controller raises busy late, so this cycle never looks at it.
          tmo     <= '0;
          rd_done <= 1'b0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cmd_rd && !rd_done) begin
            if (mc_data_ready) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= mc_dout;
              rd_done   <= 1'b1;
            end else if (tmo == TMO_LAST) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rd_done   <= 1'b1;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end else if (!mc_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_req_scheduler.sv
// tb/tb_ddr3_req_scheduler.sv - scoreboard bench for ddr3_req_scheduler with a behavioural controller model
`timescale 1ns/1ps
module tb_ddr3_req_scheduler;

  localparam int RC = 779;
  localparam int RT = 255;
`ifdef REFRESH_POSTPONE_EN
  localparam int FIRST_TICK = 8;
  localparam int T3_REFS    = 3;
`else
  localparam int FIRST_TICK = 1;
  localparam int T3_REFS    = 10;
`endif

  logic        pclk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [25:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        mc_rd, mc_wr, mc_refresh;
  logic [25:0] mc_addr;
  logic [15:0] mc_din;
  logic [15:0] mc_dout = 16'h0;
  logic        mc_data_ready = 1'b0;
  logic        mc_busy;
  logic        model_busy = 1'b0;
  logic        busy_force = 1'b0;
  logic [3:0]  refresh_credit;
  logic        refresh_overrun;
  logic [68:0] outs;

  assign mc_busy = model_busy | busy_force;
  assign outs = {req_ready, rsp_valid, rsp_rdata, rsp_err, mc_rd, mc_wr, mc_refresh,
                 mc_addr, mc_din, refresh_credit, refresh_overrun};

  always #5 pclk = ~pclk;

  ddr3_req_scheduler dut (
    .pclk(pclk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mc_rd(mc_rd), .mc_wr(mc_wr), .mc_refresh(mc_refresh),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_dout(mc_dout),
    .mc_data_ready(mc_data_ready), .mc_busy(mc_busy),
    .refresh_credit(refresh_credit), .refresh_overrun(refresh_overrun)
  );

  typedef struct packed { logic we; logic [25:0] addr; logic [15:0] din; } cmd_t;
  typedef struct packed { logic err; logic [15:0] data; } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   ref_times[$];
  cmd_t mc;
  rsp_t mr;

  int n_checks = 0;
  int n_fail   = 0;
  int gcyc = 0, rcyc = 0;
  int n_wr = 0, n_rd = 0, n_ref = 0, n_rsp = 0;
  int last_rd_cyc = 0, last_rsp_cyc = 0;
  int t3_refs = 0, t3_d = 0;
  logic t3_on = 1'b0;

  logic        m_active = 1'b0, m_is_rd = 1'b0, no_data = 1'b0;
  logic [25:0] m_addr = '0;
  int          m_cnt = 0, m_end = 0, rd_lat = 0;
  logic [15:0] mem [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge pclk) begin
    gcyc <= gcyc + 1;
    if (!resetn) rcyc <= 0;
    else rcyc <= rcyc + 1;
  end

  // Controller model: busy one cycle after a pulse, read data after rd_lat, optional silent read.
  always @(negedge pclk) begin
    if (!resetn) begin
      m_active = 1'b0; model_busy = 1'b0; mc_data_ready = 1'b0; m_cnt = 0;
    end else begin
      mc_data_ready = 1'b0;
      if (m_active) begin
        m_cnt++;
        if (m_cnt == 1) model_busy = 1'b1;
        if (m_is_rd && !no_data && m_cnt == 2 + rd_lat) begin
          mc_dout = mem[m_addr[7:0]]; mc_data_ready = 1'b1;
        end
        if (m_is_rd && no_data && m_cnt == 280) begin
          mc_dout = 16'hbeef; mc_data_ready = 1'b1;
        end
        if (m_cnt >= m_end) begin
          model_busy = 1'b0; m_active = 1'b0;
        end
      end else if (mc_wr || mc_rd || mc_refresh) begin
        m_active = 1'b1; m_cnt = 0; m_is_rd = mc_rd; m_addr = mc_addr;
        if (mc_wr) mem[mc_addr[7:0]] = mc_din;
        m_end = mc_rd ? (no_data ? 300 : 3 + rd_lat) : 2;
      end
    end
  end

  // Monitor: pops expected commands/responses whenever the DUT presents them.
  always @(negedge pclk) begin
    if (resetn) begin
      if (mc_wr || mc_rd) begin
        if (mc_rd) begin n_rd++; last_rd_cyc = gcyc; end
        else n_wr++;
        if (cmd_q.size() == 0) chk("unexpected_cmd", {mc_wr, mc_rd}, 2'b00);
        else begin
          mc = cmd_q.pop_front();
          chk("cmd_kind", {mc_wr, mc_rd, mc_refresh}, {mc.we, !mc.we, 1'b0});
          chk("cmd_addr", mc_addr, mc.addr);
          if (mc.we) chk("cmd_din", mc_din, mc.din);
        end
      end
      if (mc_refresh) begin
        n_ref++;
        ref_times.push_back(rcyc);
        if (t3_on) begin
          t3_d = rcyc - RC * (FIRST_TICK + t3_refs);
          n_checks++;
          if (t3_d < 1 || t3_d > 4) begin
            n_fail++;
            $display("FAIL t3_ref_lat: refresh %0d cycles after tick, required 1..4", t3_d);
          end
          t3_refs++;
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        last_rsp_cyc = gcyc;
        if (rsp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 1'b0);
        else begin
          mr = rsp_q.pop_front();
          chk("rsp_err", rsp_err, mr.err);
          chk("rsp_rdata", rsp_rdata, mr.data);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [25:0] a, input logic [15:0] d,
                      input logic [15:0] er, input logic ee);
    int n = 0;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    #1;
    while (!req_ready && n < 3000) begin
      @(negedge pclk); #2; n++;
    end
    chk("send_accept", req_ready, 1'b1);
    if (req_ready) begin
      cmd_q.push_back(cmd_t'({we, a, d}));
      if (!we) rsp_q.push_back(rsp_t'({ee, er}));
    end
    @(negedge pclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0 || m_active) && n < 3000) begin
      @(negedge pclk); #2; n++;
    end
    chk("drain_done", n < 3000, 1'b1);
    repeat (4) @(negedge pclk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge pclk);
    #1 resetn = 1'b1;
    #1;
  endtask

  initial begin
    int n, i, w0, r0, s0, p0, viol;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge pclk);
    #1 chk("reset_outputs", outs, 69'h0);
    resetn = 1'b1;
    #1 chk("ready_after_reset", req_ready, 1'b1);

    // T1: write/read pairs including address extremes
    w0 = n_wr; r0 = n_rd; s0 = n_rsp;
    send(1'b1, 26'h0000001, 16'h5678, 16'h0, 1'b0);
    send(1'b0, 26'h0000001, 16'h0, 16'h5678, 1'b0);
    drain();
    chk("t1_wr_pulses", n_wr - w0, 1);
    chk("t1_rd_pulses", n_rd - r0, 1);
    chk("t1_rsp_count", n_rsp - s0, 1);
    send(1'b1, 26'h3FFFFFF, 16'hFFFF, 16'h0, 1'b0);
    send(1'b1, 26'h0000000, 16'h0001, 16'h0, 1'b0);
    send(1'b0, 26'h3FFFFFF, 16'h0, 16'hFFFF, 1'b0);
    send(1'b0, 26'h0000000, 16'h0, 16'h0001, 1'b0);
    drain();

    // T4: read timeout, late data ignored
    no_data = 1'b1;
    s0 = n_rsp;
    send(1'b0, 26'h0000002, 16'h0, 16'h0000, 1'b1);
    n = 0;
    while (n_rsp == s0 && n < 1000) begin @(negedge pclk); #2; n++; end
    chk("t4_rsp_seen", n_rsp - s0, 1);
    chk("t4_timeout_lat", last_rsp_cyc - last_rd_cyc, 2 + RT);
    drain();
    repeat (10) @(negedge pclk);
    chk("t4_no_second_rsp", n_rsp - s0, 1);
    no_data = 1'b0;

    // T6: reset during a read's WAIT_DONE
    rd_lat = 20;
    r0 = n_rd;
    send(1'b0, 26'h0000001, 16'h0, 16'h5678, 1'b0);
    n = 0;
    while (n_rd == r0 && n < 100) begin @(negedge pclk); #2; n++; end
    repeat (5) @(negedge pclk);
    #1 resetn = 1'b0;
    #1 chk("t6_outputs_in_reset", outs, 69'h0);
    rsp_q.delete();
    cmd_q.delete();
    repeat (2) @(negedge pclk);
    #1 resetn = 1'b1;
    rd_lat = 0;
    #1;
    s0 = n_rsp;
    send(1'b0, 26'h0000001, 16'h0, 16'h5678, 1'b0);
    drain();
    chk("t6_read_after_reset", n_rsp - s0, 1);

    // T2: idle refresh cadence
    do_reset();
    ref_times.delete();
    while (rcyc < 3 * RC + 20) begin @(negedge pclk); #1; end
    chk("t2_refresh_count", ref_times.size(), 3);
    if (ref_times.size() == 3) begin
      chk("t2_first_refresh", ref_times[0], RC + 1);
      chk("t2_spacing_1", ref_times[1] - ref_times[0], RC);
      chk("t2_spacing_2", ref_times[2] - ref_times[1], RC);
    end
    chk("t2_credit_zero", refresh_credit, 4'd0);

    // T3: continuous write traffic over ten refresh intervals
    do_reset();
    t3_refs = 0;
    t3_on = 1'b1;
    i = 0;
    while (rcyc < 10 * RC + 10) begin
      send(1'b1, 26'(i * 7), 16'(i * 3 + 1), 16'h0, 1'b0);
      i++;
    end
    t3_on = 1'b0;
    chk("t3_refresh_count", t3_refs, T3_REFS);
    chk("t3_no_overrun", refresh_overrun, 1'b0);
    drain();

    // T5: controller busy during init
    req_valid = 1'b0;
    resetn = 1'b0;
    busy_force = 1'b1;
    repeat (2) @(negedge pclk);
    #1 resetn = 1'b1;
    p0 = n_wr + n_rd + n_ref;
    w0 = n_wr;
    req_we = 1'b1; req_addr = 26'h10; req_wdata = 16'hA5A5; req_valid = 1'b1;
    viol = 0;
    repeat (1000) begin
      @(negedge pclk); #2;
      if (req_ready) viol++;
    end
    chk("t5_ready_low", viol, 0);
    chk("t5_no_pulses", n_wr + n_rd + n_ref - p0, 0);
    busy_force = 1'b0;
    send(1'b1, 26'h10, 16'hA5A5, 16'h0, 1'b0);
    drain();
    chk("t5_write_after_init", n_wr - w0, 1);

    chk("final_cmd_q_empty", cmd_q.size(), 0);
    chk("final_rsp_q_empty", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
